// File: rtl/ps2_key_tracker.sv
// PS/2 keyboard receiver and two-slot held-key table for the pong paddles.
// Frames are deserialised from a debounced ps2_clk; make/break sequences
// maintain keycode1 (oldest held key) and keycode2 (newest held key).
//
// Timing reference, with F the cycle in which the internal fall pulse is high:
//   rx_byte/rx_strobe or frame_err at F+1, keycode update and key_valid at F+2.
module ps2_key_tracker #(
    parameter int FILT_LEN    = 4,
    parameter int TIMEOUT_CYC = 25000
) (
    input  logic       vga_clk,
    input  logic       sys_rst_n,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    output logic [7:0] keycode1,
    output logic [7:0] keycode2,
    output logic       key_valid,
    output logic [7:0] rx_byte,
    output logic       rx_strobe,
    output logic       frame_err
);

    localparam int FW = $clog2(FILT_LEN + 1);
    localparam int TW = $clog2(TIMEOUT_CYC + 1);

    typedef enum logic {RX_IDLE, RX_SHIFT} rx_state_t;
    typedef enum logic [1:0] {D_NORM, D_BRK, D_EXT, D_EXT_BRK} dec_state_t;

    logic [1:0]   clk_sync;
    logic [1:0]   data_sync;
    logic         clk_filt;
    logic [FW-1:0] filt_cnt;
    logic         fall;

    rx_state_t    rx_state;
    logic [3:0]   bit_cnt;
    logic [7:0]   shift_reg;
    logic         par_bit;
    logic [TW-1:0] tmo_cnt;

    dec_state_t   dec_state;
    dec_state_t   dec_next;
    logic [7:0]   next_k1;
    logic [7:0]   next_k2;
    logic         code_ignored;

    // Two-flop synchronisers; reset to the idle-high line level.
    always_ff @(posedge vga_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            clk_sync  <= 2'b11;
            data_sync <= 2'b11;
        end else begin
            clk_sync  <= {clk_sync[0], ps2_clk};
            data_sync <= {data_sync[0], ps2_data};
        end
    end

    // Glitch filter: the filtered clock follows only after FILT_LEN consecutive
    // differing samples; the fall pulse is registered alongside the 1->0 change.
    always_ff @(posedge vga_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            clk_filt <= 1'b1;
            filt_cnt <= '0;
            fall     <= 1'b0;
        end else begin
            fall <= 1'b0;
            if (clk_sync[1] == clk_filt) begin
                filt_cnt <= '0;
            end else if (filt_cnt == FW'(FILT_LEN - 1)) begin
                filt_cnt <= '0;
                clk_filt <= clk_sync[1];
                fall     <= clk_filt & ~clk_sync[1];
            end else begin
                filt_cnt <= filt_cnt + 1'b1;
            end
        end
    end

    // Frame receiver: start, 8 data bits LSB first, odd parity, stop.
    // The timeout counter reads k-1 in cycle F+k, so comparing against
    // TIMEOUT_CYC-2 puts the timeout error pulse exactly TIMEOUT_CYC cycles after F.
    always_ff @(posedge vga_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            rx_state  <= RX_IDLE;
            bit_cnt   <= '0;
            shift_reg <= '0;
            par_bit   <= 1'b0;
            tmo_cnt   <= '0;
            rx_byte   <= '0;
            rx_strobe <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            rx_strobe <= 1'b0;
            frame_err <= 1'b0;
            case (rx_state)
                RX_IDLE: begin
                    tmo_cnt <= '0;
                    if (fall) begin
                        if (!data_sync[1]) begin
                            rx_state <= RX_SHIFT;
                            bit_cnt  <= 4'd1;
                        end else begin
                            frame_err <= 1'b1;
                        end
                    end
                end
                RX_SHIFT: begin
                    if (fall) begin
                        tmo_cnt <= '0;
                        if (bit_cnt <= 4'd8) begin
                            shift_reg <= {data_sync[1], shift_reg[7:1]};
                            bit_cnt   <= bit_cnt + 4'd1;
                        end else if (bit_cnt == 4'd9) begin
                            par_bit <= data_sync[1];
                            bit_cnt <= bit_cnt + 4'd1;
                        end else begin
                            rx_state <= RX_IDLE;
                            bit_cnt  <= '0;
                            if (data_sync[1] && (^{shift_reg, par_bit})) begin
                                rx_byte   <= shift_reg;
                                rx_strobe <= 1'b1;
                            end else begin
                                frame_err <= 1'b1;
                            end
                        end
                    end else if (tmo_cnt == TW'(TIMEOUT_CYC - 2)) begin
                        frame_err <= 1'b1;
                        rx_state  <= RX_IDLE;
                        bit_cnt   <= '0;
                        tmo_cnt   <= '0;
                    end else begin
                        tmo_cnt <= tmo_cnt + 1'b1;
                    end
                end
                default: rx_state <= RX_IDLE;
            endcase
        end
    end

    assign code_ignored = (rx_byte == 8'h00) || (rx_byte == 8'hAA) || (rx_byte == 8'hFA) ||
                          (rx_byte == 8'hFE) || (rx_byte == 8'hFF);

    // Decoder next state and key-table update for the byte just strobed.
    always_comb begin
        dec_next = dec_state;
        next_k1  = keycode1;
        next_k2  = keycode2;
        if (rx_strobe) begin
            case (dec_state)
                D_NORM: begin
                    if (rx_byte == 8'hF0) begin
                        dec_next = D_BRK;
                    end else if (rx_byte == 8'hE0) begin
                        dec_next = D_EXT;
                    end else if (!code_ignored &&
                                 rx_byte != keycode1 && rx_byte != keycode2) begin
                        if (keycode1 == 8'h00)      next_k1 = rx_byte;
                        else                        next_k2 = rx_byte;
                    end
                end
                D_BRK: begin
                    dec_next = D_NORM;
                    if (rx_byte == keycode1) begin
                        next_k1 = keycode2;
                        next_k2 = 8'h00;
                    end else if (rx_byte == keycode2) begin
                        next_k2 = 8'h00;
                    end
                end
                D_EXT:     dec_next = (rx_byte == 8'hF0) ? D_EXT_BRK : D_NORM;
                D_EXT_BRK: dec_next = D_NORM;
                default:   dec_next = D_NORM;
            endcase
        end
    end

    // Register the key table; key_valid flags a real change of either slot.
    always_ff @(posedge vga_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            dec_state <= D_NORM;
            keycode1  <= 8'h00;
            keycode2  <= 8'h00;
            key_valid <= 1'b0;
        end else begin
            dec_state <= dec_next;
            keycode1  <= next_k1;
            keycode2  <= next_k2;
            key_valid <= (next_k1 != keycode1) || (next_k2 != keycode2);
        end
    end

endmodule

// File: tb/tb_ps2_key_tracker.sv
// Directed bench for ps2_key_tracker: drives PS/2 frames bit by bit and
// checks the key table, pulse counts and pulse timing against hand values.
module tb_ps2_key_tracker;

    localparam int FILT_LEN    = 4;
    localparam int TIMEOUT_CYC = 25000;
    localparam int HALF        = 20;   // vga_clk cycles per PS/2 clock half period
    localparam int FALL_LAT    = 6;    // drive of ps2_clk low -> internal fall cycle

    logic       vga_clk = 1'b0;
    logic       sys_rst_n;
    logic       ps2_clk;
    logic       ps2_data;
    logic [7:0] keycode1;
    logic [7:0] keycode2;
    logic       key_valid;
    logic [7:0] rx_byte;
    logic       rx_strobe;
    logic       frame_err;

    int vec_cnt = 0;
    int err_cnt = 0;
    int cyc = 0;
    int strobe_count = 0, kv_count = 0, ferr_count = 0;
    int last_strobe_cyc = 0, last_kv_cyc = 0, last_err_cyc = 0;
    int last_fall_cyc = 0;

    ps2_key_tracker #(.FILT_LEN(FILT_LEN), .TIMEOUT_CYC(TIMEOUT_CYC)) dut (
        .vga_clk   (vga_clk),
        .sys_rst_n (sys_rst_n),
        .ps2_clk   (ps2_clk),
        .ps2_data  (ps2_data),
        .keycode1  (keycode1),
        .keycode2  (keycode2),
        .key_valid (key_valid),
        .rx_byte   (rx_byte),
        .rx_strobe (rx_strobe),
        .frame_err (frame_err)
    );

    // Clock and cycle counter.
    always #20 vga_clk = ~vga_clk;
    always @(posedge vga_clk) cyc = cyc + 1;

    // Pulse monitor sampling on the inactive edge.
    always @(negedge vga_clk) begin
        if (rx_strobe) begin strobe_count++; last_strobe_cyc = cyc; end
        if (key_valid) begin kv_count++;     last_kv_cyc     = cyc; end
        if (frame_err) begin ferr_count++;   last_err_cyc    = cyc; end
    end

    // Send the first n bits of an 11-bit frame (bit 0 = start) LSB first.
    task automatic send_bits(input logic [10:0] frame, input int n);
        for (int i = 0; i < n; i++) begin
            ps2_data = frame[i];
            repeat (HALF) @(negedge vga_clk);
            ps2_clk = 1'b0;
            last_fall_cyc = cyc;
            repeat (HALF) @(negedge vga_clk);
            ps2_clk = 1'b1;
        end
        ps2_data = 1'b1;
        repeat (HALF) @(negedge vga_clk);
    endtask

    task automatic send_frame(input logic [7:0] b, input logic flip_par, input logic stop);
        send_bits({stop, (~^b) ^ flip_par, b, 1'b0}, 11);
    endtask

    task automatic send_byte(input logic [7:0] b);
        send_frame(b, 1'b0, 1'b1);
    endtask

    task automatic test_reset;
        vec_cnt++;
        if ({keycode1, keycode2, rx_byte} !== 24'h0) begin
            err_cnt++;
            $display("FAIL reset_regs: k1=%h k2=%h rx_byte=%h, need 00 00 00", keycode1, keycode2, rx_byte);
        end
        vec_cnt++;
        if ({key_valid, rx_strobe, frame_err} !== 3'b000) begin
            err_cnt++;
            $display("FAIL reset_pulses: kv/strb/err=%b, need 000", {key_valid, rx_strobe, frame_err});
        end
    endtask

    task automatic test_single_frame;
        int c0;
        send_byte(8'h1C);
        c0 = last_fall_cyc;
        vec_cnt++;
        if (rx_byte !== 8'h1C || last_strobe_cyc !== c0 + FALL_LAT + 1) begin
            err_cnt++;
            $display("FAIL frame_1c_rx: byte=%h strobe_at=%0d, need 1c at %0d", rx_byte, last_strobe_cyc - c0, FALL_LAT + 1);
        end
        vec_cnt++;
        if (keycode1 !== 8'h1C || keycode2 !== 8'h00 || last_kv_cyc !== c0 + FALL_LAT + 2) begin
            err_cnt++;
            $display("FAIL frame_1c_key: k1=%h k2=%h kv_at=%0d, need 1c 00 at %0d", keycode1, keycode2, last_kv_cyc - c0, FALL_LAT + 2);
        end
        send_byte(8'hF0); send_byte(8'h1C);
        vec_cnt++;
        if (keycode1 !== 8'h00 || keycode2 !== 8'h00) begin
            err_cnt++;
            $display("FAIL release_1c: k1=%h k2=%h, need 00 00", keycode1, keycode2);
        end
    endtask

    task automatic test_make_repeat;
        int kv0;
        kv0 = kv_count;
        send_byte(8'h1B); send_byte(8'h4B); send_byte(8'h4B);
        vec_cnt++;
        if (keycode1 !== 8'h1B || keycode2 !== 8'h4B) begin
            err_cnt++;
            $display("FAIL two_keys: k1=%h k2=%h, need 1b 4b", keycode1, keycode2);
        end
        vec_cnt++;
        if (kv_count - kv0 !== 2) begin
            err_cnt++;
            $display("FAIL repeat_kv_count: got %0d pulses, need 2", kv_count - kv0);
        end
    endtask

    task automatic test_break;
        send_byte(8'hF0); send_byte(8'h1B);
        vec_cnt++;
        if (keycode1 !== 8'h4B || keycode2 !== 8'h00) begin
            err_cnt++;
            $display("FAIL break_compact: k1=%h k2=%h, need 4b 00", keycode1, keycode2);
        end
        send_byte(8'hF0); send_byte(8'h4B);
        vec_cnt++;
        if (keycode1 !== 8'h00 || keycode2 !== 8'h00) begin
            err_cnt++;
            $display("FAIL break_last: k1=%h k2=%h, need 00 00", keycode1, keycode2);
        end
    endtask

    task automatic test_replace;
        int kv0;
        send_byte(8'h1B); send_byte(8'h4B); send_byte(8'h44);
        vec_cnt++;
        if (keycode1 !== 8'h1B || keycode2 !== 8'h44) begin
            err_cnt++;
            $display("FAIL replace_newer: k1=%h k2=%h, need 1b 44", keycode1, keycode2);
        end
        kv0 = kv_count;
        send_byte(8'hF0); send_byte(8'h1D);
        vec_cnt++;
        if (keycode1 !== 8'h1B || keycode2 !== 8'h44 || kv_count !== kv0) begin
            err_cnt++;
            $display("FAIL break_not_held: k1=%h k2=%h kv=%0d, need 1b 44 0", keycode1, keycode2, kv_count - kv0);
        end
        send_byte(8'hF0); send_byte(8'h44);
        vec_cnt++;
        if (keycode1 !== 8'h1B || keycode2 !== 8'h00) begin
            err_cnt++;
            $display("FAIL break_slot2: k1=%h k2=%h, need 1b 00", keycode1, keycode2);
        end
        send_byte(8'hF0); send_byte(8'h1B);
    endtask

    task automatic test_frame_errors;
        int e0, s0, c0;
        send_byte(8'h1C);
        e0 = ferr_count; s0 = strobe_count;
        send_frame(8'h1D, 1'b1, 1'b1);
        c0 = last_fall_cyc;
        vec_cnt++;
        if (ferr_count - e0 !== 1 || strobe_count !== s0 || last_err_cyc !== c0 + FALL_LAT + 1) begin
            err_cnt++;
            $display("FAIL bad_parity: errs=%0d strobes=%0d err_at=%0d, need 1 0 %0d",
                     ferr_count - e0, strobe_count - s0, last_err_cyc - c0, FALL_LAT + 1);
        end
        e0 = ferr_count;
        send_frame(8'h1D, 1'b0, 1'b0);
        vec_cnt++;
        if (ferr_count - e0 !== 1 || strobe_count !== s0) begin
            err_cnt++;
            $display("FAIL bad_stop: errs=%0d strobes=%0d, need 1 0", ferr_count - e0, strobe_count - s0);
        end
        vec_cnt++;
        if (keycode1 !== 8'h1C || keycode2 !== 8'h00 || rx_byte !== 8'h1C) begin
            err_cnt++;
            $display("FAIL err_keys_kept: k1=%h k2=%h rx=%h, need 1c 00 1c", keycode1, keycode2, rx_byte);
        end
        send_byte(8'hF0); send_byte(8'h1C);
    endtask

    task automatic test_timeout;
        int e0, c0;
        e0 = ferr_count;
        send_bits({1'b1, 1'b0, 8'h5A, 1'b0}, 5);
        c0 = last_fall_cyc;
        while (cyc < c0 + FALL_LAT + TIMEOUT_CYC + 30) @(negedge vga_clk);
        vec_cnt++;
        if (ferr_count - e0 !== 1 || last_err_cyc !== c0 + FALL_LAT + TIMEOUT_CYC) begin
            err_cnt++;
            $display("FAIL timeout: errs=%0d err_at=%0d, need 1 at %0d",
                     ferr_count - e0, last_err_cyc - c0, FALL_LAT + TIMEOUT_CYC);
        end
        send_byte(8'h1C);
        vec_cnt++;
        if (keycode1 !== 8'h1C || keycode2 !== 8'h00) begin
            err_cnt++;
            $display("FAIL after_timeout: k1=%h k2=%h, need 1c 00", keycode1, keycode2);
        end
    endtask

    task automatic test_extended;
        int kv0;
        kv0 = kv_count;
        send_byte(8'hE0); send_byte(8'h75);
        send_byte(8'hE0); send_byte(8'hF0); send_byte(8'h75);
        send_byte(8'hAA);
        vec_cnt++;
        if (keycode1 !== 8'h1C || keycode2 !== 8'h00 || kv_count !== kv0) begin
            err_cnt++;
            $display("FAIL extended_ignored: k1=%h k2=%h kv=%0d, need 1c 00 0", keycode1, keycode2, kv_count - kv0);
        end
        send_byte(8'h29);
        vec_cnt++;
        if (keycode1 !== 8'h1C || keycode2 !== 8'h29) begin
            err_cnt++;
            $display("FAIL back_to_norm: k1=%h k2=%h, need 1c 29", keycode1, keycode2);
        end
    endtask

    task automatic test_reset_mid_frame;
        send_byte(8'hF0);
        send_bits({1'b1, 1'b0, 8'h1C, 1'b0}, 3);
        ps2_clk = 1'b0;
        repeat (3) @(negedge vga_clk);
        sys_rst_n = 1'b0;
        repeat (2) @(negedge vga_clk);
        vec_cnt++;
        if ({keycode1, keycode2, rx_byte, key_valid, rx_strobe, frame_err} !== 27'h0) begin
            err_cnt++;
            $display("FAIL reset_mid_frame: k1=%h k2=%h rx=%h kv/strb/err=%b, need all 0",
                     keycode1, keycode2, rx_byte, {key_valid, rx_strobe, frame_err});
        end
        ps2_clk = 1'b1; ps2_data = 1'b1;
        repeat (HALF) @(negedge vga_clk);
        sys_rst_n = 1'b1;
        repeat (HALF) @(negedge vga_clk);
        send_byte(8'h1C);
        vec_cnt++;
        if (keycode1 !== 8'h1C || keycode2 !== 8'h00) begin
            err_cnt++;
            $display("FAIL f0_cleared_by_reset: k1=%h k2=%h, need 1c 00", keycode1, keycode2);
        end
    endtask

    initial begin
        sys_rst_n = 1'b0;
        ps2_clk   = 1'b1;
        ps2_data  = 1'b1;
        repeat (5) @(negedge vga_clk);
        test_reset;
        sys_rst_n = 1'b1;
        repeat (5) @(negedge vga_clk);
        test_single_frame;
        test_make_repeat;
        test_break;
        test_replace;
        test_frame_errors;
        test_timeout;
        test_extended;
        test_reset_mid_frame;
        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule
